mcu_port_fifo: RTL and testbench

// - Buffers and sequences the MCU serial-port channel between the system-control block's port interface and the core UART.
// - RX FIFO carries UART->MCU bytes. TX FIFO carries MCU->UART bytes.
// - Produces the available/free counts and the packed 32-bit port status word consumed by system control.

---
 rtl/mcu_port_pkg.sv | 37 +++
 rtl/mcu_port_fifo_sync_fifo.sv | 59 +++++
 rtl/mcu_port_fifo.sv | 96 +++++++++
 tb/tb_mcu_port_fifo.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_port_pkg.sv
// Shared constants and helpers for the MCU serial-port FIFO block.
package mcu_port_pkg;

  localparam logic [7:0] PORT_TYPE_SERIAL = 8'd0;

  // Bit offsets of each byte inside the 32-bit port status word
  localparam int unsigned ST_BR_LO  = 24;
  localparam int unsigned ST_BR_MID = 16;
  localparam int unsigned ST_BR_HI  = 8;
  localparam int unsigned ST_FMT    = 0;

  localparam int unsigned STATUS_W  = 32;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_ODD  = 2'd1,
    PARITY_EVEN = 2'd2
  } parity_e;

  // Clamp a count of up to 9 bits to an 8-bit field
  function automatic logic [7:0] sat_u8(input logic [8:0] val);
    return val[8] ? 8'hFF : val[7:0];
  endfunction

  // Byte-swapped bitrate followed by the format byte
  function automatic logic [STATUS_W-1:0] pack_status(input logic [23:0] bitrate,
                                                      input logic [7:0]  format);
    logic [STATUS_W-1:0] word;
    word = '0;
    word[ST_BR_LO  +: 8] = bitrate[7:0];
    word[ST_BR_MID +: 8] = bitrate[15:8];
    word[ST_BR_HI  +: 8] = bitrate[23:16];
    word[ST_FMT    +: 8] = format;
    return word;
  endfunction

endpackage

// File: rtl/mcu_port_fifo_sync_fifo.sv
// First-word-fall-through synchronous FIFO with distributed-RAM storage.
module sync_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  push,
  input  logic [WIDTH-1:0]      din,
  input  logic                  pop,
  output logic [WIDTH-1:0]      dout,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned AW    = DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             pop_eff;
  logic             push_eff;
  logic             wipe;

  assign wipe     = reset || clr;
  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  // Pop on empty is ignored; a push on full is accepted only alongside a real pop
  assign pop_eff  = pop && !empty;
  assign push_eff = push && (!full || pop_eff);
  assign dout     = mem[rptr];

  // Pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (wipe) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_eff) wptr <= wptr + AW'(1);
      if (pop_eff)  rptr <= rptr + AW'(1);
      case ({push_eff, pop_eff})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents are not reset
  always_ff @(posedge clk) begin
    if (push_eff && !wipe) mem[wptr] <= din;
  end

endmodule

// File: rtl/mcu_port_fifo.sv
// MCU serial-port channel: RX/TX FIFOs, saturated counts, overrun flags and status word.
module mcu_port_fifo
  import mcu_port_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  output logic [7:0]  port_out_available,
  output logic [7:0]  port_out_data,
  input  logic        port_out_strobe,
  output logic [7:0]  port_in_available,
  input  logic [7:0]  port_in_data,
  input  logic        port_in_strobe,
  output logic [31:0] port_status,
  input  logic [23:0] cfg_bitrate,
  input  logic [7:0]  cfg_format,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        rx_overrun,
  output logic        tx_overrun
);

  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [CW-1:0] rx_count;
  logic [CW-1:0] tx_count;
  logic [CW-1:0] tx_free;
  logic          rx_full;
  logic          rx_empty;
  logic          tx_full;
  logic          tx_empty;
  logic          tx_pop;
  logic          rx_drop;
  logic          tx_drop;

  sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .push  (rx_valid),
    .din   (rx_data),
    .pop   (port_out_strobe),
    .dout  (port_out_data),
    .count (rx_count),
    .full  (rx_full),
    .empty (rx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .push  (port_in_strobe),
    .din   (port_in_data),
    .pop   (tx_pop),
    .dout  (tx_data),
    .count (tx_count),
    .full  (tx_full),
    .empty (tx_empty)
  );

  assign tx_valid = !tx_empty;
  assign tx_pop   = tx_valid && tx_ready;

  // A full FIFO is never empty, so a simultaneous pop always frees a slot
  assign rx_drop  = rx_valid && rx_full && !(port_out_strobe && !rx_empty);
  assign tx_drop  = port_in_strobe && tx_full && !tx_pop;

  assign tx_free            = CW'(DEPTH) - tx_count;
  assign port_out_available = sat_u8(9'(rx_count));
  assign port_in_available  = sat_u8(9'(tx_free));

  // Sticky overrun flags, cleared by reset or flush
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rx_overrun <= 1'b0;
      tx_overrun <= 1'b0;
    end else begin
      if (rx_drop) rx_overrun <= 1'b1;
      if (tx_drop) tx_overrun <= 1'b1;
    end
  end

  // Registered status word mirroring the UART configuration
  always_ff @(posedge clk) begin
    if (reset) port_status <= '0;
    else       port_status <= pack_status(cfg_bitrate, cfg_format);
  end

endmodule

// File: tb/tb_mcu_port_fifo.sv
// Scoreboard bench for mcu_port_fifo: directed stimulus, queue-based byte checking.
module tb_mcu_port_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [7:0]  port_out_available;
  logic [7:0]  port_out_data;
  logic        port_out_strobe;
  logic [7:0]  port_in_available;
  logic [7:0]  port_in_data;
  logic        port_in_strobe;
  logic [31:0] port_status;
  logic [23:0] cfg_bitrate;
  logic [7:0]  cfg_format;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_overrun;
  logic        tx_overrun;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_tx[$];
  bit done = 1'b0;

  always #5 clk = ~clk;

  mcu_port_fifo #(.DEPTH_LOG2(4)) dut (
    .clk                (clk),
    .reset              (reset),
    .flush              (flush),
    .port_out_available (port_out_available),
    .port_out_data      (port_out_data),
    .port_out_strobe    (port_out_strobe),
    .port_in_available  (port_in_available),
    .port_in_data       (port_in_data),
    .port_in_strobe     (port_in_strobe),
    .port_status        (port_status),
    .cfg_bitrate        (cfg_bitrate),
    .cfg_format         (cfg_format),
    .rx_valid           (rx_valid),
    .rx_data            (rx_data),
    .tx_valid           (tx_valid),
    .tx_data            (tx_data),
    .tx_ready           (tx_ready),
    .rx_overrun         (rx_overrun),
    .tx_overrun         (tx_overrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted byte on either output is compared to the scoreboard head
  always @(negedge clk) begin
    if (!done && reset === 1'b0 && flush === 1'b0) begin
      if (port_out_strobe && port_out_available != 8'd0) begin
        if (exp_rx.size() == 0) chk("rx_unexpected_pop", 32'(port_out_data), 32'hDEAD);
        else chk("rx_byte", 32'(port_out_data), 32'(exp_rx.pop_front()));
      end
      if (tx_valid && tx_ready) begin
        if (exp_tx.size() == 0) chk("tx_unexpected_byte", 32'(tx_data), 32'hDEAD);
        else chk("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic rx_push(input logic [7:0] b, input bit expect_kept);
    rx_valid = 1'b1;
    rx_data  = b;
    if (expect_kept) exp_rx.push_back(b);
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic tx_push(input logic [7:0] b, input bit expect_kept);
    port_in_strobe = 1'b1;
    port_in_data   = b;
    if (expect_kept) exp_tx.push_back(b);
    tick();
    port_in_strobe = 1'b0;
  endtask

  task automatic rx_pops(input int n);
    port_out_strobe = 1'b1;
    repeat (n) tick();
    port_out_strobe = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    port_out_strobe = 1'b0; port_in_strobe = 1'b0; port_in_data = '0;
    cfg_bitrate = '0; cfg_format = '0;
    rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset / idle state
    sample();
    chk("rst_out_avail", 32'(port_out_available), 32'd0);
    chk("rst_in_avail", 32'(port_in_available), 32'd16);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_status", port_status, 32'h0);
    chk("rst_overruns", {30'd0, rx_overrun, tx_overrun}, 32'd0);

    // RX path
    rx_push(8'h11, 1'b1);
    rx_push(8'h22, 1'b1);
    rx_push(8'h33, 1'b1);
    sample();
    chk("rx_avail3", 32'(port_out_available), 32'd3);
    chk("rx_head", 32'(port_out_data), 32'h11);
    tick();
    port_out_strobe = 1'b1;
    tick();
    port_out_strobe = 1'b0;
    sample();
    chk("rx_head_after_pop", 32'(port_out_data), 32'h22);
    rx_pops(2);
    sample();
    chk("rx_avail0", 32'(port_out_available), 32'd0);

    // RX full: 17 pushes, last one dropped
    tick();
    for (int i = 0; i < 17; i++) rx_push(8'(8'h40 + i), i < 16);
    sample();
    chk("rxfull_avail", 32'(port_out_available), 32'd16);
    chk("rxfull_overrun", 32'(rx_overrun), 32'd1);
    tick();
    rx_valid = 1'b1; rx_data = 8'h99; port_out_strobe = 1'b1;
    exp_rx.push_back(8'h99);
    tick();
    rx_valid = 1'b0; port_out_strobe = 1'b0;
    sample();
    chk("rxfull_pushpop_avail", 32'(port_out_available), 32'd16);
    chk("rxfull_pushpop_overrun", 32'(rx_overrun), 32'd1);
    tick();
    rx_pops(16);
    sample();
    chk("rxfull_drained", 32'(port_out_available), 32'd0);

    // Pop on empty is ignored
    tick();
    rx_pops(2);
    sample();
    chk("rx_empty_pop", 32'(port_out_available), 32'd0);

    // TX handshake
    tick();
    tx_push(8'hA5, 1'b1);
    tx_push(8'h5A, 1'b1);
    sample();
    chk("tx_valid1", 32'(tx_valid), 32'd1);
    chk("tx_head", 32'(tx_data), 32'hA5);
    chk("tx_in_avail14", 32'(port_in_available), 32'd14);
    tick();
    tx_ready = 1'b1;
    repeat (2) tick();
    tx_ready = 1'b0;
    sample();
    chk("tx_drained_valid", 32'(tx_valid), 32'd0);
    chk("tx_drained_avail", 32'(port_in_available), 32'd16);

    // TX full
    tick();
    for (int i = 0; i < 17; i++) tx_push(8'(8'hC0 + i), i < 16);
    sample();
    chk("txfull_avail", 32'(port_in_available), 32'd0);
    chk("txfull_overrun", 32'(tx_overrun), 32'd1);
    tick();
    tx_ready = 1'b1;
    repeat (16) tick();
    tx_ready = 1'b0;
    sample();
    chk("txfull_drained", 32'(port_in_available), 32'd16);
    chk("txfull_overrun_sticky", 32'(tx_overrun), 32'd1);

    // Status packing
    tick();
    cfg_bitrate = 24'h01C200; cfg_format = 8'h08;
    tick();
    sample();
    chk("status_115200", port_status, 32'h00C20108);
    tick();
    cfg_bitrate = 24'h123456; cfg_format = 8'hD7;
    tick();
    sample();
    chk("status_alt", port_status, 32'h563412D7);

    // Flush mid-stream
    tick();
    for (int i = 0; i < 5; i++) rx_push(8'(8'h70 + i), 1'b1);
    for (int i = 0; i < 3; i++) tx_push(8'(8'hE0 + i), 1'b1);
    sample();
    chk("preflush_out_avail", 32'(port_out_available), 32'd5);
    chk("preflush_in_avail", 32'(port_in_available), 32'd13);
    tick();
    flush = 1'b1; tx_ready = 1'b1;
    tick();
    flush = 1'b0;
    exp_rx.delete();
    exp_tx.delete();
    sample();
    chk("flush_out_avail", 32'(port_out_available), 32'd0);
    chk("flush_in_avail", 32'(port_in_available), 32'd16);
    chk("flush_tx_valid", 32'(tx_valid), 32'd0);
    chk("flush_overruns", {30'd0, rx_overrun, tx_overrun}, 32'd0);
    tick();
    rx_pops(2);
    sample();
    chk("flush_pop_ignored", 32'(port_out_available), 32'd0);
    tx_ready = 1'b0;

    // Reset mid-transfer
    tick();
    tx_push(8'h3C, 1'b1);
    tx_push(8'hC3, 1'b1);
    reset = 1'b1; tx_ready = 1'b1;
    tick();
    reset = 1'b0;
    exp_tx.delete();
    sample();
    chk("reset_tx_valid", 32'(tx_valid), 32'd0);
    chk("reset_in_avail", 32'(port_in_available), 32'd16);
    chk("reset_status", port_status, 32'h0);
    tick();
    tx_ready = 1'b0;
    tick();

    chk("rx_scoreboard_empty", 32'(exp_rx.size()), 32'd0);
    chk("tx_scoreboard_empty", 32'(exp_tx.size()), 32'd0);
    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
